instruction_queue: RTL

Parametrised instruction buffer between fetch and `instruction_decode`. It accepts up to FETCH_WIDTH program-ordered instruction words per cycle from fetch, tags each word with its own PC, and presents one instruction per cycle to decode over a valid/ready handshake. A single-cycle flush discards all queued instructions on a branch redirect or exception.

---
 rtl/instruction_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instruction_queue.sv
// instruction_queue: circular instruction buffer between fetch and decode.
//   Fetch side : fetch_valid/fetch_ready beat of up to FETCH_WIDTH words.
//                fetch_count gives the number of valid words. fetch_pc is
//                the PC of word 0. Word k is fetch_instructions[32k +: 32].
//   Decode side: decode_valid/decode_ready, head word and its PC.
//   Status     : free_slots (DEPTH - occupancy), empty.
//   flush empties the queue in one edge. rst (sync, active-low) also
//   zeroes the storage.

// Per-lane write address, enable and PC for fetch word LANE of a beat.
module iq_lane #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int LANE        = 0,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int FC_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic             enq,
  input  logic [FC_W-1:0]  cnt,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [31:0]      base_pc,
  output logic             we,
  output logic [PTR_W-1:0] slot,
  output logic [31:0]      pc
);
  assign we   = enq && (cnt > FC_W'(LANE));
  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  assign slot = wr_ptr + PTR_W'(LANE);
  assign pc   = base_pc + 32'(4 * LANE);
endmodule

module instruction_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               fetch_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   fetch_count,
  input  logic [31:0]                        fetch_pc,
  input  logic [32*FETCH_WIDTH-1:0]          fetch_instructions,
  output logic                               fetch_ready,
  output logic                               decode_valid,
  input  logic                               decode_ready,
  output logic [31:0]                        decode_instruction,
  output logic [31:0]                        decode_pc,
  output logic [$clog2(DEPTH+1)-1:0]         free_slots,
  output logic                               empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FC_W  = $clog2(FETCH_WIDTH + 1);

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } iq_entry_t;

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] occ;

  logic [FC_W-1:0]  cnt_c;
  logic             enq, deq;

  logic [FETCH_WIDTH-1:0]            lane_we;
  logic [FETCH_WIDTH-1:0][PTR_W-1:0] lane_slot;
  logic [FETCH_WIDTH-1:0][31:0]      lane_pc;
  logic [FETCH_WIDTH-1:0][31:0]      lane_ins;

  // Out-of-range counts are clamped rather than trusted.
  assign cnt_c = (fetch_count > FC_W'(FETCH_WIDTH)) ? FC_W'(FETCH_WIDTH) : fetch_count;

  assign free_slots   = CNT_W'(DEPTH) - occ;
  assign empty        = (occ == '0);
  // Ready looks only at current occupancy, never at decode_ready.
  assign fetch_ready  = (free_slots >= CNT_W'(FETCH_WIDTH));
  assign decode_valid = !empty;
  assign decode_instruction = mem[rd_ptr].ins;
  assign decode_pc          = mem[rd_ptr].pc;

  assign enq = fetch_valid && fetch_ready;
  assign deq = decode_valid && decode_ready;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    assign lane_ins[k] = fetch_instructions[32*k +: 32];
    iq_lane #(
      .DEPTH(DEPTH), .FETCH_WIDTH(FETCH_WIDTH), .LANE(k)
    ) u_lane (
      .enq    (enq),
      .cnt    (cnt_c),
      .wr_ptr (wr_ptr),
      .base_pc(fetch_pc),
      .we     (lane_we[k]),
      .slot   (lane_slot[k]),
      .pc     (lane_pc[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the pointers are dropped.
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      // Lanes of one beat always hit distinct slots (count <= DEPTH).
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (lane_we[k]) mem[lane_slot[k]] <= '{ins: lane_ins[k], pc: lane_pc[k]};
      if (enq) wr_ptr <= wr_ptr + PTR_W'(cnt_c);
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (enq ? CNT_W'(cnt_c) : CNT_W'(0)) - (deq ? CNT_W'(1) : CNT_W'(0));
    end
  end
endmodule
